// File: rtl/codec_ctrl_pkg.sv
// Shared types, widths and byte-format helpers for the codec configuration sequencer.
package codec_ctrl_pkg;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 9;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned BCNT_W  = 2;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BYTE_W  = 8;

  // Byte counter value of the final (data low) byte of a register write.
  localparam logic [BCNT_W-1:0] LAST_BYTE    = 2'd2;
  // err_index reported when a host single write fails.
  localparam logic [IDX_W-1:0]  HOST_ERR_IDX = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BYTE,
    S_ACK_WAIT,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  // One codec register write: 7-bit register address and 9-bit value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_word_t;

  // Byte n of the three-byte write frame: device address, addr+data msb, data low.
  function automatic logic [BYTE_W-1:0] wr_byte(input logic [ADDR_W-1:0] dev,
                                                input cfg_word_t         w,
                                                input logic [BCNT_W-1:0] n);
    logic [BYTE_W-1:0] b;
    case (n)
      2'd0:    b = {dev, 1'b0};
      2'd1:    b = {w.addr, w.data[DATA_W-1]};
      default: b = w.data[BYTE_W-1:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Power-up register table for the audio codec, indexed by table position.
module codec_cfg_rom
  import codec_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output cfg_word_t        word_o
);

  // Combinational lookup; unused indices read as zero.
  always_comb begin
    word_o = '0;
    case (idx_i)
      4'd0:    word_o = {7'h0F, 9'h000}; // reset
      4'd1:    word_o = {7'h06, 9'h010}; // power down control
      4'd2:    word_o = {7'h00, 9'h017}; // left line in
      4'd3:    word_o = {7'h01, 9'h017}; // right line in
      4'd4:    word_o = {7'h02, 9'h079}; // left headphone
      4'd5:    word_o = {7'h03, 9'h079}; // right headphone
      4'd6:    word_o = {7'h04, 9'h012}; // analog path
      4'd7:    word_o = {7'h05, 9'h000}; // digital path
      4'd8:    word_o = {7'h07, 9'h00A}; // digital audio interface
      4'd9:    word_o = {7'h09, 9'h001}; // activate
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// Codec configuration sequencer: plays the register table (or one host write)
// through an I2C byte engine, with ACK timeout, retry and inter-write gap.
module codec_cfg_seq
  import codec_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] C_DEV_ADDR    = 7'h1A,
  parameter int unsigned       C_NUM_REGS    = 10,
  parameter int unsigned       C_MAX_RETRY   = 3,
  parameter logic [CNT_W-1:0]  C_ACK_TIMEOUT = 16'd1024,
  parameter logic [CNT_W-1:0]  C_GAP_CYCLES  = 16'd512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_req,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [IDX_W-1:0]  err_index,
  output logic              eng_go,
  output logic              eng_rnw,
  output logic [BYTE_W-1:0] eng_wdata,
  input  logic              eng_done,
  input  logic              eng_ack
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic                nack_q, nack_d;
  logic                host_q, host_d;
  cfg_word_t           word_q, word_d;
  cfg_word_t           rom_word;
  logic                busy_q, busy_d;
  logic                go_q, go_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;

  codec_cfg_rom u_rom (
    .idx_i  (idx_q),
    .word_o (rom_word)
  );

  // Host handshake is only offered when idle and no table start competes.
  assign wr_ready  = (state_q == S_IDLE) && !start && !rst;
  assign busy      = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign err_index = err_idx_q;
  assign eng_go    = go_q;
  assign eng_rnw   = 1'b0;
  assign eng_wdata = wdata_q;

  // Next-state and datapath decisions for the write sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    nack_d    = nack_q;
    host_d    = host_q;
    word_d    = word_q;
    go_d      = go_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          host_d  = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (wr_req) begin
          state_d = S_LOAD;
          host_d  = 1'b1;
          word_d  = {wr_addr, wr_data};
          retry_d = '0;
        end
      end
      S_LOAD: begin
        if (!host_q) word_d = rom_word;
        wdata_d = wr_byte(C_DEV_ADDR, word_q, 2'd0);
        bcnt_d  = '0;
        nack_d  = 1'b0;
        tmo_d   = '0;
        gap_d   = '0;
        go_d    = 1'b1;
        state_d = S_BYTE;
      end
      S_BYTE: begin
        if (eng_done) begin
          wdata_d = wr_byte(C_DEV_ADDR, word_q, BCNT_W'(bcnt_q + 2'd1));
          tmo_d   = '0;
          if (bcnt_q == LAST_BYTE || nack_q) go_d = 1'b0;
          state_d = S_ACK_WAIT;
        end
      end
      S_ACK_WAIT: begin
        if (eng_ack) begin
          if (bcnt_q != 2'd3) bcnt_d = BCNT_W'(bcnt_q + 2'd1);
          if (bcnt_q != LAST_BYTE && !nack_q) begin
            state_d = S_BYTE;
          end else begin
            go_d    = 1'b0;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (tmo_q >= C_ACK_TIMEOUT - CNT_W'(1)) begin
          nack_d  = 1'b1;
          go_d    = 1'b0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        go_d = 1'b0;
        if (gap_q >= C_GAP_CYCLES - CNT_W'(1)) begin
          if (nack_q) begin
            if (retry_q < RETRY_W'(C_MAX_RETRY)) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = S_LOAD;
            end else begin
              state_d = S_ERR;
            end
          end else if (host_q || idx_q == IDX_W'(C_NUM_REGS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = S_LOAD;
          end
        end else if (gap_q != '1) begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!host_q) done_d = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d     = 1'b1;
        err_idx_d = host_q ? HOST_ERR_IDX : idx_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      bcnt_q    <= '0;
      retry_q   <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
      nack_q    <= 1'b0;
      host_q    <= 1'b0;
      word_q    <= '0;
      busy_q    <= 1'b0;
      go_q      <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      nack_q    <= nack_d;
      host_q    <= host_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      go_q      <= go_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Directed bench for codec_cfg_seq with a behavioural I2C byte-engine model.
module tb_codec_cfg_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start, wr_req, wr_ready;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy, cfg_done, cfg_err;
  logic [3:0] err_index;
  logic       eng_go, eng_rnw;
  logic [7:0] eng_wdata;
  logic       eng_done = 1'b0;
  logic       eng_ack  = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-computed second and third bytes for table entries 0..9.
  logic [7:0] exp_b1 [10] = '{8'h1E, 8'h0C, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0E, 8'h12};
  logic [7:0] exp_b2 [10] = '{8'h00, 8'h10, 8'h17, 8'h17, 8'h79, 8'h79, 8'h12, 8'h00, 8'h0A, 8'h01};

  logic [7:0] log_q [$];
  logic [7:0] exp_q [$];
  int         nack_mode = 0;
  int         nack_base = 0;
  int         nack_count = 0;

  always #5 clk = ~clk;

  codec_cfg_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wr_req    (wr_req),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .err_index (err_index),
    .eng_go    (eng_go),
    .eng_rnw   (eng_rnw),
    .eng_wdata (eng_wdata),
    .eng_done  (eng_done),
    .eng_ack   (eng_ack)
  );

  // Byte engine: shift a byte while go is high, pulse done, then ACK or abort on NACK.
  int         eph = 0, ecnt = 0, pos = 0, cur_pos = 0;
  bit         in_tx = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      eph = 0; ecnt = 0; in_tx = 1'b0; eng_done = 1'b0; eng_ack = 1'b0;
    end else begin
      case (eph)
        0: begin
          if (eng_go) begin
            if (!in_tx) begin in_tx = 1'b1; pos = 0; end
            cur_byte = eng_wdata;
            cur_pos  = pos;
            pos++;
            log_q.push_back(eng_wdata);
            ecnt = 0;
            eph  = 1;
          end else begin
            in_tx = 1'b0;
          end
        end
        1: begin
          ecnt++;
          if (ecnt == 3) begin eng_done = 1'b1; ecnt = 0; eph = 2; end
        end
        2: begin
          eng_done = 1'b0;
          ecnt++;
          if (ecnt == 2) begin
            if (cur_pos == 1 &&
                ((nack_mode == 1 && nack_count == nack_base && cur_byte == 8'h02) ||
                 (nack_mode == 2 && cur_byte == 8'h06))) begin
              nack_count++;
              eph = 4;
            end else begin
              eng_ack = 1'b1;
              eph = 3;
            end
          end
        end
        3: begin eng_ack = 1'b0; eph = 0; end
        4: if (!eng_go) begin in_tx = 1'b0; eph = 0; end
        default: eph = 0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input int i);
    exp_q.push_back(8'h34);
    exp_q.push_back(exp_b1[i]);
    exp_q.push_back(exp_b2[i]);
  endtask

  task automatic compare_log(input int base, input string tag);
    int n;
    n = log_q.size() - base;
    check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(log_q[base+i]), 32'(exp_q[i]));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 30000) begin @(negedge clk); n++; end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic host_write(input logic [6:0] a, input logic [8:0] d, input string tag);
    int n;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    n = 0;
    while (!wr_ready && n < 30000) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    start = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values while rst is held.
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_go",       32'(eng_go),    32'd0);
    check("rst_wdata",    32'(eng_wdata), 32'd0);
    check("rst_done",     32'(cfg_done),  32'd0);
    check("rst_err",      32'(cfg_err),   32'd0);
    check("rst_err_idx",  32'(err_index), 32'd0);
    check("rst_wr_ready", 32'(wr_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_wr_ready", 32'(wr_ready), 32'd1);
    check("rnw",           32'(eng_rnw),  32'd0);

    // Full table, every byte acknowledged.
    base = log_q.size(); exp_q.delete();
    for (int i = 0; i < 10; i++) push_tx(i);
    pulse_start();
    check("tbl_busy", 32'(busy), 32'd1);
    wait_idle("tbl");
    compare_log(base, "tbl");
    check("tbl_done",    32'(cfg_done),  32'd1);
    check("tbl_err",     32'(cfg_err),   32'd0);
    check("tbl_err_idx", 32'(err_index), 32'd0);

    // Host single write leaves the flags alone.
    base = log_q.size(); exp_q.delete();
    exp_q.push_back(8'h34); exp_q.push_back(8'h08); exp_q.push_back(8'h12);
    host_write(7'h04, 9'h012, "host");
    check("host_busy", 32'(busy), 32'd1);
    wait_idle("host");
    compare_log(base, "host");
    check("host_done", 32'(cfg_done), 32'd1);
    check("host_err",  32'(cfg_err),  32'd0);

    // One NACK on byte 1 of index 3: that index is retried once.
    nack_mode = 1; nack_base = nack_count;
    base = log_q.size(); exp_q.delete();
    for (int i = 0; i < 3; i++) push_tx(i);
    exp_q.push_back(8'h34); exp_q.push_back(8'h02);
    for (int i = 3; i < 10; i++) push_tx(i);
    pulse_start();
    wait_idle("retry");
    compare_log(base, "retry");
    check("retry_done", 32'(cfg_done), 32'd1);
    check("retry_err",  32'(cfg_err),  32'd0);
    nack_mode = 0;

    // Index 5 always NACKed: four attempts then error.
    nack_mode = 2;
    base = log_q.size(); exp_q.delete();
    for (int i = 0; i < 5; i++) push_tx(i);
    for (int k = 0; k < 4; k++) begin exp_q.push_back(8'h34); exp_q.push_back(8'h06); end
    pulse_start();
    wait_idle("fail");
    compare_log(base, "fail");
    check("fail_err",     32'(cfg_err),   32'd1);
    check("fail_err_idx", 32'(err_index), 32'd5);
    check("fail_done",    32'(cfg_done),  32'd0);
    nack_mode = 0;

    // start and wr_req together: table first, then the host write.
    base = log_q.size(); exp_q.delete();
    for (int i = 0; i < 10; i++) push_tx(i);
    exp_q.push_back(8'h34); exp_q.push_back(8'h0B); exp_q.push_back(8'h06);
    wr_addr = 7'h05; wr_data = 9'h106; wr_req = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("both_no_ready", 32'(wr_ready), 32'd0);
    host_write(7'h05, 9'h106, "both");
    wait_idle("both");
    compare_log(base, "both");
    check("both_done", 32'(cfg_done), 32'd1);
    check("both_err",  32'(cfg_err),  32'd0);

    // Reset in the middle of byte 1 of index 2.
    base = log_q.size();
    pulse_start();
    n = 0;
    while ((log_q.size() - base) < 8 && n < 30000) begin @(negedge clk); n++; end
    check("mid_reach", 32'(log_q.size() - base), 32'd8);
    check("mid_go_before", 32'(eng_go), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_go",       32'(eng_go),    32'd0);
    check("mid_wdata",    32'(eng_wdata), 32'd0);
    check("mid_busy",     32'(busy),      32'd0);
    check("mid_wr_ready", 32'(wr_ready),  32'd0);
    check("mid_done",     32'(cfg_done),  32'd0);
    check("mid_err",      32'(cfg_err),   32'd0);
    check("mid_err_idx",  32'(err_index), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_go",       32'(eng_go),   32'd0);
    check("post_busy",     32'(busy),     32'd0);
    check("post_wr_ready", 32'(wr_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
